// File: rtl/conv_seq_ctrl.sv
// Sequencer for the three-channel convolution MAC engine.
// Walks a KxK window over the feature map, issues RAM reads, steers the
// engine enable and writes one summed result per window position.
module conv_seq_ctrl #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int FM_AW  = 16,
  parameter int W_AW   = 8,
  parameter int O_AW   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             fm_rd_en,
  output logic [FM_AW-1:0] fm_addr,
  output logic             w_rd_en,
  output logic [W_AW-1:0]  w_addr,
  output logic             mac_en,
  output logic [9:0]       mac_size,
  input  logic             mac_ack,
  input  logic [31:0]      mac_r,
  input  logic [31:0]      mac_g,
  input  logic [31:0]      mac_b,
  output logic             out_we,
  output logic [O_AW-1:0]  out_addr,
  output logic [33:0]      out_data,
  output logic             err
);

  localparam int OW = (IMG_W - K) / STRIDE + 1;
  localparam int OH = (IMG_H - K) / STRIDE + 1;
  localparam int N  = K * K;
  localparam int CW = 16;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ox_q, ox_d, oy_q, oy_d, kx_q, kx_d, ky_q, ky_d;
  logic            busy_q, busy_d, done_q, done_d, out_we_q, out_we_d;
  logic            err_q, err_d, mac_en_q, mac_en_d;
  logic [O_AW-1:0] out_addr_q, out_addr_d;
  logic [33:0]     out_data_q, out_data_d;
  logic            last_tap, last_win;

  assign last_tap = (kx_q == CW'(K - 1)) && (ky_q == CW'(K - 1));
  assign last_win = (ox_q == CW'(OW - 1)) && (oy_q == CW'(OH - 1));

  // Read strobes and addresses are decoded straight from the window counters.
  always_comb begin
    fm_rd_en = (state_q == FETCH);
    w_rd_en  = (state_q == FETCH);
    fm_addr  = '0;
    w_addr   = '0;
    if (state_q == FETCH) begin
      fm_addr = FM_AW'((32'(oy_q) * 32'(STRIDE) + 32'(ky_q)) * 32'(IMG_W)
                       + 32'(ox_q) * 32'(STRIDE) + 32'(kx_q));
      w_addr  = W_AW'(32'(ky_q) * 32'(K) + 32'(kx_q));
    end
  end

  // Next-state logic: tap walk in FETCH, window advance and result capture in FLUSH.
  always_comb begin
    state_d    = state_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    out_we_d   = 1'b0;
    err_d      = err_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    mac_en_d   = (state_q == FETCH);
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d = FETCH;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          ox_d    = '0;
          oy_d    = '0;
          kx_d    = '0;
          ky_d    = '0;
        end
      end
      FETCH: begin
        if (last_tap) begin
          kx_d    = '0;
          ky_d    = '0;
          state_d = DRAIN;
        end else if (kx_q == CW'(K - 1)) begin
          kx_d = '0;
          ky_d = ky_q + CW'(1);
        end else begin
          kx_d = kx_q + CW'(1);
        end
      end
      DRAIN: begin
        state_d = FLUSH;
      end
      FLUSH: begin
        if (!mac_ack) err_d = 1'b1;
        out_data_d = {2'b00, mac_r} + {2'b00, mac_g} + {2'b00, mac_b};
        out_addr_d = O_AW'(32'(oy_q) * 32'(OW) + 32'(ox_q));
        out_we_d   = 1'b1;
        if (ox_q == CW'(OW - 1)) begin
          ox_d = '0;
          oy_d = oy_q + CW'(1);
        end else begin
          ox_d = ox_q + CW'(1);
        end
        if (last_win) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          oy_d    = '0;
        end else begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any pass in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ox_q       <= '0;
      oy_q       <= '0;
      kx_q       <= '0;
      ky_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_we_q   <= 1'b0;
      err_q      <= 1'b0;
      mac_en_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      out_we_q   <= out_we_d;
      err_q      <= err_d;
      mac_en_q   <= mac_en_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_we   = out_we_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign err      = err_q;
  assign mac_en   = mac_en_q | (state_q == FLUSH);
  assign mac_size = 10'(N + 1);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: 4x4/K3/S1 instance with a behavioural engine and
// RAMs, plus a 5x5/K3/S2 instance for strided window starts.
module tb_conv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start, start2;
  logic        busy, done, fmRdEn, wRdEn, macEn, macAck, outWe, err;
  logic [15:0] fmAddr, outAddr;
  logic [7:0]  wAddr;
  logic [9:0]  macSize;
  logic [31:0] macR, macG, macB;
  logic [33:0] outData;

  logic        busy2, done2, fmRdEn2, wRdEn2, macEn2, outWe2, err2;
  logic [15:0] fmAddr2, outAddr2;
  logic [7:0]  wAddr2;
  logic [9:0]  macSize2;
  logic [33:0] outData2;

  logic        stubNoAck, stubMax;
  logic [31:0] fmMem [16];
  logic [31:0] wMem  [16];
  logic [31:0] fmQ, wQ, engAcc;
  logic [9:0]  engCnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          cyc;
    logic        rd;
    logic [15:0] fmA;
    logic [7:0]  wA;
    logic        en;
    logic        we;
    logic [15:0] oA;
    logic [33:0] oD;
    logic        dn;
  } vec_t;

  vec_t tbl [15];

  always #5 clk = ~clk;

  conv_seq_ctrl #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1)) dut (
    .clk(clk), .rst_n(rstN), .start(start), .busy(busy), .done(done),
    .fm_rd_en(fmRdEn), .fm_addr(fmAddr), .w_rd_en(wRdEn), .w_addr(wAddr),
    .mac_en(macEn), .mac_size(macSize), .mac_ack(macAck),
    .mac_r(macR), .mac_g(macG), .mac_b(macB),
    .out_we(outWe), .out_addr(outAddr), .out_data(outData), .err(err)
  );

  conv_seq_ctrl #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2)) dut2 (
    .clk(clk), .rst_n(rstN), .start(start2), .busy(busy2), .done(done2),
    .fm_rd_en(fmRdEn2), .fm_addr(fmAddr2), .w_rd_en(wRdEn2), .w_addr(wAddr2),
    .mac_en(macEn2), .mac_size(macSize2), .mac_ack(1'b1),
    .mac_r(32'd0), .mac_g(32'd0), .mac_b(32'd0),
    .out_we(outWe2), .out_addr(outAddr2), .out_data(outData2), .err(err2)
  );

  // Synchronous-read feature-map and weight RAMs
  always @(posedge clk) begin
    if (fmRdEn) fmQ <= fmMem[fmAddr[3:0]];
    if (wRdEn)  wQ  <= wMem[wAddr[3:0]];
  end

  // Behavioural engine: Size-1 data beats accumulate, Size-th beat flushes with ack
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      engCnt <= '0;
      engAcc <= '0;
    end else if (macEn) begin
      if (engCnt == macSize - 10'd1) begin
        engCnt <= '0;
        engAcc <= '0;
      end else begin
        engCnt <= engCnt + 10'd1;
        engAcc <= engAcc + fmQ * wQ;
      end
    end
  end

  assign macAck = macEn && (engCnt == macSize - 10'd1) && !stubNoAck;
  assign macR   = stubMax ? 32'hFFFF_FFFF : engAcc;
  assign macG   = stubMax ? 32'hFFFF_FFFF : engAcc;
  assign macB   = stubMax ? 32'hFFFF_FFFF : engAcc;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s);
    start = s;
    @(negedge clk);
  endtask

  // One full pass on the 4x4 instance; s1/s2 are cycles where a stray start is driven
  task automatic runTablePass(input int s1, input int s2);
    applyStimulus(1'b1);
    for (int c = 0; c <= 44; c++) begin
      if (c < 44) checkOutput("busy", 64'(busy), 64'd1);
      checkOutput("fm_rd_en", 64'(fmRdEn), 64'((c < 44) && ((c % 11) < 9)));
      checkOutput("out_we", 64'(outWe), 64'((c > 0) && ((c % 11) == 0)));
      for (int i = 0; i < 15; i++) begin
        if (tbl[i].cyc == c) begin
          checkOutput("fm_addr", 64'(fmAddr), 64'(tbl[i].fmA));
          checkOutput("w_addr", 64'(wAddr), 64'(tbl[i].wA));
          checkOutput("w_rd_en", 64'(wRdEn), 64'(tbl[i].rd));
          checkOutput("mac_en", 64'(macEn), 64'(tbl[i].en));
          checkOutput("done", 64'(done), 64'(tbl[i].dn));
          if (tbl[i].we) begin
            checkOutput("out_addr", 64'(outAddr), 64'(tbl[i].oA));
            checkOutput("out_data", 64'(outData), 64'(tbl[i].oD));
          end
        end
      end
      applyStimulus((c == s1) || (c == s2));
    end
    checkOutput("busy_after", 64'(busy), 64'd0);
    checkOutput("rd_after", 64'(fmRdEn), 64'd0);
    checkOutput("err_pass", 64'(err), 64'd0);
  endtask

  initial begin
    logic weSeen;
    tbl[0]  = '{0,  1'b1, 16'd0,  8'd0, 1'b0, 1'b0, 16'd0, 34'd0,  1'b0};
    tbl[1]  = '{1,  1'b1, 16'd1,  8'd1, 1'b1, 1'b0, 16'd0, 34'd0,  1'b0};
    tbl[2]  = '{2,  1'b1, 16'd2,  8'd2, 1'b1, 1'b0, 16'd0, 34'd0,  1'b0};
    tbl[3]  = '{3,  1'b1, 16'd4,  8'd3, 1'b1, 1'b0, 16'd0, 34'd0,  1'b0};
    tbl[4]  = '{4,  1'b1, 16'd5,  8'd4, 1'b1, 1'b0, 16'd0, 34'd0,  1'b0};
    tbl[5]  = '{5,  1'b1, 16'd6,  8'd5, 1'b1, 1'b0, 16'd0, 34'd0,  1'b0};
    tbl[6]  = '{6,  1'b1, 16'd8,  8'd6, 1'b1, 1'b0, 16'd0, 34'd0,  1'b0};
    tbl[7]  = '{7,  1'b1, 16'd9,  8'd7, 1'b1, 1'b0, 16'd0, 34'd0,  1'b0};
    tbl[8]  = '{8,  1'b1, 16'd10, 8'd8, 1'b1, 1'b0, 16'd0, 34'd0,  1'b0};
    tbl[9]  = '{9,  1'b0, 16'd0,  8'd0, 1'b1, 1'b0, 16'd0, 34'd0,  1'b0};
    tbl[10] = '{10, 1'b0, 16'd0,  8'd0, 1'b1, 1'b0, 16'd0, 34'd0,  1'b0};
    tbl[11] = '{11, 1'b1, 16'd1,  8'd0, 1'b0, 1'b1, 16'd0, 34'd27, 1'b0};
    tbl[12] = '{22, 1'b1, 16'd4,  8'd0, 1'b0, 1'b1, 16'd1, 34'd27, 1'b0};
    tbl[13] = '{33, 1'b1, 16'd5,  8'd0, 1'b0, 1'b1, 16'd2, 34'd27, 1'b0};
    tbl[14] = '{44, 1'b0, 16'd0,  8'd0, 1'b0, 1'b1, 16'd3, 34'd27, 1'b1};
    for (int i = 0; i < 16; i++) begin
      fmMem[i] = 32'd1;
      wMem[i]  = 32'd1;
    end
    stubNoAck = 1'b0;
    stubMax   = 1'b0;
    start     = 1'b0;
    start2    = 1'b0;
    rstN      = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_rd", 64'(fmRdEn), 64'd0);
    checkOutput("rst_mac_en", 64'(macEn), 64'd0);
    checkOutput("rst_out_we", 64'(outWe), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("mac_size", 64'(macSize), 64'd10);
    rstN = 1'b1;
    @(negedge clk);

    $display("[TB] strided 5x5 K3 S2 window starts");
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c <= 44; c++) begin
      if (c == 0)  checkOutput("s2_win00", 64'(fmAddr2), 64'd0);
      if (c == 11) checkOutput("s2_win10", 64'(fmAddr2), 64'd2);
      if (c == 22) checkOutput("s2_win01", 64'(fmAddr2), 64'd10);
      if (c == 33) checkOutput("s2_win11", 64'(fmAddr2), 64'd12);
      if (c == 44) begin
        checkOutput("s2_done", 64'(done2), 64'd1);
        checkOutput("s2_out_addr", 64'(outAddr2), 64'd3);
        checkOutput("s2_err", 64'(err2), 64'd0);
      end
      @(negedge clk);
    end

    $display("[TB] baseline pass");
    runTablePass(-1, -1);

    $display("[TB] start during busy and on done cycle");
    runTablePass(5, 44);
    applyStimulus(1'b1);
    start = 1'b0;
    checkOutput("restart_busy", 64'(busy), 64'd1);
    checkOutput("restart_fm", 64'(fmAddr), 64'd0);
    repeat (23) @(negedge clk);
    checkOutput("pre_reset_fm", 64'(fmAddr), 64'd5);
    rstN = 1'b0;
    #1;
    checkOutput("async_busy", 64'(busy), 64'd0);
    checkOutput("async_rd", 64'(fmRdEn), 64'd0);
    checkOutput("async_fm", 64'(fmAddr), 64'd0);
    checkOutput("async_mac_en", 64'(macEn), 64'd0);
    checkOutput("async_out_we", 64'(outWe), 64'd0);
    checkOutput("async_out_addr", 64'(outAddr), 64'd0);
    checkOutput("async_out_data", 64'(outData), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    weSeen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (outWe || busy) weSeen = 1'b1;
    end
    checkOutput("no_write_after_reset", 64'(weSeen), 64'd0);
    runTablePass(-1, -1);

    $display("[TB] missing ack and wide sum");
    stubNoAck = 1'b1;
    stubMax   = 1'b1;
    applyStimulus(1'b1);
    start = 1'b0;
    for (int c = 0; c <= 45; c++) begin
      if (c == 10) checkOutput("err_before_flush", 64'(err), 64'd0);
      if (c == 11) begin
        checkOutput("err_set", 64'(err), 64'd1);
        checkOutput("sum_34bit", 64'(outData), 64'h2_FFFF_FFFD);
      end
      if (c == 44) begin
        checkOutput("err_hold", 64'(err), 64'd1);
        checkOutput("done_noack", 64'(done), 64'd1);
      end
      if (c == 45) checkOutput("err_idle", 64'(err), 64'd1);
      if (c < 45) @(negedge clk);
    end
    stubNoAck = 1'b0;
    stubMax   = 1'b0;
    applyStimulus(1'b1);
    start = 1'b0;
    checkOutput("err_cleared", 64'(err), 64'd0);
    repeat (11) @(negedge clk);
    checkOutput("post_err_data", 64'(outData), 64'd27);
    repeat (34) @(negedge clk);
    checkOutput("post_err_idle", 64'(busy), 64'd0);
    checkOutput("post_err_err", 64'(err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
